// File: rtl/vending_credit_ctrl.sv
// vending_credit_ctrl: coin credit accumulation, dispense sequencing and quarter-by-quarter change return.
// Optional idle refund timeout enabled by defining VEND_TIMEOUT_EN.
module vending_credit_ctrl #(
  parameter int PRICE_Q      = 3,
  parameter int MAX_CREDIT_Q = 12,
  parameter int CREDIT_W     = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Q_in,
  input  logic                D_in,
  input  logic                cancel,
  output logic                dispense,
  input  logic                dispense_ack,
  output logic                change,
  input  logic                change_ack,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  state_t state;
  logic [CREDIT_W:0] add, sum;
  logic coin, fits, take;
  if (PRICE_Q < 1 || PRICE_Q > MAX_CREDIT_Q || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("vending_credit_ctrl: illegal parameter set");
  end
  // sum is one bit wider than credit so an over-limit add cannot wrap
  assign add  = {{(CREDIT_W-2){1'b0}}, D_in, 1'b0, Q_in};
  assign sum  = {1'b0, credit} + add;
  assign coin = Q_in | D_in;
  assign fits = sum <= (CREDIT_W+1)'(MAX_CREDIT_Q);
  assign take = coin && fits && !(state == COLLECT && cancel);
`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  logic expire;
  assign expire = state == COLLECT && cnt == CNT_W'(TIMEOUT_CYC - 1) && !take;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      change      <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      coin_reject <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt <= (state == COLLECT && !take) ? cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE, COLLECT: begin
          if (state == COLLECT && cancel) begin
            state       <= CHANGE;
            change      <= 1'b1;
            busy        <= 1'b1;
            coin_reject <= coin;
          end else if (coin && !fits) begin
            coin_reject <= 1'b1;
          end else if (coin && sum >= (CREDIT_W+1)'(PRICE_Q)) begin
            credit   <= CREDIT_W'(sum - (CREDIT_W+1)'(PRICE_Q));
            dispense <= 1'b1;
            busy     <= 1'b1;
            state    <= DISPENSE;
          end else if (coin) begin
            credit <= sum[CREDIT_W-1:0];
            state  <= COLLECT;
          end
`ifdef VEND_TIMEOUT_EN
          else if (expire) begin
            state  <= CHANGE;
            change <= 1'b1;
            busy   <= 1'b1;
          end
`endif
        end
        DISPENSE: begin
          coin_reject <= coin;
          if (dispense_ack) begin
            dispense <= 1'b0;
            change   <= credit != '0;
            busy     <= credit != '0;
            state    <= (credit != '0) ? CHANGE : IDLE;
          end
        end
        default: begin
          coin_reject <= coin;
          if (change_ack) begin
            credit <= credit - 1'b1;
            if (credit == CREDIT_W'(1)) begin
              change <= 1'b0;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule
